fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch controller directly downstream of the program counter.
- Takes the current PC, runs a read transaction on instruction memory (variable latency, busywait handshake), and loads the IF/ID pipeline register.
- Drives busyWait back to the PC so the PC advances exactly once per fetched instruction. It also honours hazard-unit stalls and branch flushes.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- INSTR_WIDTH, 32, instruction word width.
- NOP_INSTR, 32'h00000013, value loaded into IF/ID on reset/flush (addi x0,x0,0).

Ports:
- CLK  input  1  clock, all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- PC  input  ADDR_WIDTH  current program counter from PC stage.
- STALL  input  1  hazard unit: hold IF/ID, launch no new fetch.
- BRANCH_FLUSH  input  1  branch/jump taken: squash IF/ID and in-flight fetch.
- busyWait  output  1  to PC stage: 1 = PC must hold, 0 = PC loads nextPC this edge.
- imem_read  output  1  read request to instruction memory (registered).
- imem_address  output  ADDR_WIDTH  request address, stable while imem_read=1.
- imem_readdata  input  INSTR_WIDTH  instruction, valid when imem_busywait=0 with imem_read=1.
- imem_busywait  input  1  memory not ready.
- IF_ID_PC  output  ADDR_WIDTH  PC of instruction in IF/ID.
- IF_ID_INSTR  output  INSTR_WIDTH  instruction in IF/ID.
- IF_ID_VALID  output  1  IF/ID holds a real instruction.

Behaviour:
- Interface: one clock, CLK; reset is RESET, synchronous and active-high. Polarity and synchronicity are fixed.
- Reset values: state=IDLE, imem_read=0, imem_address=0, IF_ID_PC=0, IF_ID_INSTR=NOP_INSTR, IF_ID_VALID=0, hold buffer empty. RESET overrides every other input.
- States: IDLE, REQ, HOLD, DROP.
- IDLE:
  - If !STALL && !BRANCH_FLUSH, latch imem_address<=PC, imem_read<=1, and go to REQ.
  - Otherwise stay in IDLE.
- REQ, when imem_busywait=0 at the edge (completion):
  - Always: imem_read<=0.
  - If !STALL: IF_ID_INSTR<=imem_readdata, IF_ID_PC<=imem_address, IF_ID_VALID<=1, go to IDLE.
  - If STALL: store {address, data} in the hold buffer and go to HOLD.
- HOLD: when STALL=0, move the buffer into IF/ID (VALID=1) and go to IDLE.
- DROP: keep imem_read=1 until imem_busywait=0, discard the data, then imem_read<=0 and go to IDLE.
- BRANCH_FLUSH (priority over STALL and completion):
  - Next edge: IF_ID_VALID<=0, IF_ID_INSTR<=NOP_INSTR, hold buffer cleared.
  - REQ with imem_busywait=1 goes to DROP. REQ completing this edge, and HOLD, go to IDLE.
- STALL without flush: IF/ID registers hold their values.
- busyWait (combinational):
  - 0 when BRANCH_FLUSH=1, so the PC takes the branch target.
  - 0 on a REQ completion edge with STALL=0.
  - 0 in HOLD with STALL=0.
  - 1 otherwise, including during IDLE, reset, and DROP.
- The PC advances exactly once per instruction delivered to IF/ID, or once per flush.
- Latency: with 1-cycle memory, PC sampled in IDLE reaches IF_ID_INSTR 2 edges later; throughput is 1 instruction per 2 cycles minimum.
- A memory response is never consumed while imem_read=0. imem_address never changes while imem_read=1.
- Reset mid-transaction: imem_read drops immediately and the in-flight data is discarded.

Decomposition:
- Shared package `cpu_pkg`:
  - NOP_INSTR constant.
  - Fetch state enum {IDLE, REQ, HOLD, DROP}.
  - ADDR_WIDTH/INSTR_WIDTH defaults.
- One natural sub-module: `fetch_hold_buffer`, a one-entry {PC, instr} register with load/clear/valid.
- The FSM and IF/ID register stay in fetch_unit.

Test Plan:
- Reset, 1-cycle memory, PC=0 then 4 → IF_ID {PC=0, instr=mem[0]} VALID=1 at edge 2, then {4, mem[1]} at edge 4; busyWait low only on completion edges.
- Memory busywait held 3 cycles at PC=8 → imem_read/imem_address=8 stable for 4 cycles, busyWait=1 throughout, IF/ID gets {8, mem[2]} once.
- STALL=1 asserted at completion of PC=0xC → IF/ID unchanged, state HOLD, busyWait=1; STALL drops 2 cycles later → IF/ID={0xC, mem[3]}, busyWait=0 for one cycle.
- BRANCH_FLUSH during REQ with memory busy (PC=0x10, target 0x40) → IF_ID_VALID=0, IF_ID_INSTR=0x00000013, busyWait=0 that cycle; data for 0x10 discarded; next fetch address=0x40.
- BRANCH_FLUSH and STALL together in HOLD → flush wins: buffer cleared, IF/ID invalid NOP, state IDLE.
- RESET asserted mid-REQ → next edge imem_read=0, IF_ID_VALID=0, IF_ID_PC=0; the late memory response is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch state encoding
package cpu_pkg;

  localparam int          DEF_ADDR_WIDTH  = 32;
  localparam int          DEF_INSTR_WIDTH = 32;
  localparam logic [31:0] DEF_NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory read port between fetch unit and imem
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
);

  logic                   imem_read;
  logic [ADDR_WIDTH-1:0]  imem_address;
  logic [INSTR_WIDTH-1:0] imem_readdata;
  logic                   imem_busywait;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_readdata,
    input  imem_busywait
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_readdata,
    output imem_busywait
  );

endinterface

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - one-entry {pc, instr} parking slot for fetches completed under stall
module fetch_hold_buffer
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   i_load,
  input  logic                   i_clear,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output logic                   o_valid,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [INSTR_WIDTH-1:0] o_instr
);

  logic                   r_valid;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;

  // clear wins over load so a flush on the parking edge leaves nothing behind
  always_ff @(posedge CLK) begin
    if (RESET || i_clear) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch controller: PC -> imem read -> IF/ID register, with stall/flush handling
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                     ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                     INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = DEF_NOP_INSTR
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [ADDR_WIDTH-1:0]  PC,
  input  logic                   STALL,
  input  logic                   BRANCH_FLUSH,
  output logic                   busyWait,
  fetch_unit_if.master           imem,
  output logic [ADDR_WIDTH-1:0]  IF_ID_PC,
  output logic [INSTR_WIDTH-1:0] IF_ID_INSTR,
  output logic                   IF_ID_VALID
);

  fetch_state_e           r_state, w_state_nxt;
  logic                   r_imem_read, w_imem_read_nxt;
  logic [ADDR_WIDTH-1:0]  r_imem_address, w_imem_address_nxt;
  logic [ADDR_WIDTH-1:0]  r_if_pc, w_if_pc_nxt;
  logic [INSTR_WIDTH-1:0] r_if_instr, w_if_instr_nxt;
  logic                   r_if_valid, w_if_valid_nxt;
  logic                   w_busy_wait;
  logic                   w_buf_load, w_buf_clear, w_buf_valid;
  logic [ADDR_WIDTH-1:0]  w_buf_pc;
  logic [INSTR_WIDTH-1:0] w_buf_instr;
  logic                   w_done;

  assign w_done = (r_state == REQ) && !imem.imem_busywait;

  fetch_hold_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_hold (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_load (w_buf_load),
    .i_clear(w_buf_clear),
    .i_pc   (r_imem_address),
    .i_instr(imem.imem_readdata),
    .o_valid(w_buf_valid),
    .o_pc   (w_buf_pc),
    .o_instr(w_buf_instr)
  );

  always_comb begin
    w_state_nxt        = r_state;
    w_imem_read_nxt    = r_imem_read;
    w_imem_address_nxt = r_imem_address;
    w_if_pc_nxt        = r_if_pc;
    w_if_instr_nxt     = r_if_instr;
    w_if_valid_nxt     = r_if_valid;
    w_busy_wait        = 1'b1;
    w_buf_load         = 1'b0;
    w_buf_clear        = 1'b0;
    if (BRANCH_FLUSH) begin
      // the PC takes the branch target now; an unfinished read is drained in DROP
      w_busy_wait    = 1'b0;
      w_if_valid_nxt = 1'b0;
      w_if_instr_nxt = NOP_INSTR;
      w_buf_clear    = 1'b1;
      if ((r_state == REQ || r_state == DROP) && imem.imem_busywait) begin
        w_state_nxt = DROP;
      end else begin
        w_state_nxt     = IDLE;
        w_imem_read_nxt = 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: if (!STALL) begin
          w_imem_address_nxt = PC;
          w_imem_read_nxt    = 1'b1;
          w_state_nxt        = REQ;
        end
        REQ: if (w_done) begin
          w_imem_read_nxt = 1'b0;
          if (!STALL) begin
            w_if_pc_nxt    = r_imem_address;
            w_if_instr_nxt = imem.imem_readdata;
            w_if_valid_nxt = 1'b1;
            w_busy_wait    = 1'b0;
            w_state_nxt    = IDLE;
          end else begin
            w_buf_load  = 1'b1;
            w_state_nxt = HOLD;
          end
        end
        HOLD: if (!STALL) begin
          w_if_pc_nxt    = w_buf_pc;
          w_if_instr_nxt = w_buf_instr;
          w_if_valid_nxt = w_buf_valid;
          w_buf_clear    = 1'b1;
          w_busy_wait    = 1'b0;
          w_state_nxt    = IDLE;
        end
        DROP: if (!imem.imem_busywait) begin
          w_imem_read_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state        <= IDLE;
      r_imem_read    <= 1'b0;
      r_imem_address <= '0;
      r_if_pc        <= '0;
      r_if_instr     <= NOP_INSTR;
      r_if_valid     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_imem_read    <= w_imem_read_nxt;
      r_imem_address <= w_imem_address_nxt;
      r_if_pc        <= w_if_pc_nxt;
      r_if_instr     <= w_if_instr_nxt;
      r_if_valid     <= w_if_valid_nxt;
    end
  end

  assign busyWait          = RESET | w_busy_wait;
  assign imem.imem_read    = r_imem_read;
  assign imem.imem_address = r_imem_address;
  assign IF_ID_PC          = r_if_pc;
  assign IF_ID_INSTR       = r_if_instr;
  assign IF_ID_VALID       = r_if_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit with a PC stage and variable-latency imem
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int             AW  = 32;
  localparam int             IW  = 32;
  localparam logic [IW-1:0]  NOP = 32'h0000_0013;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } item_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          STALL = 1'b0;
  logic          BRANCH_FLUSH = 1'b0;
  logic          busyWait;
  logic [AW-1:0] PC = '0;
  logic [AW-1:0] IF_ID_PC;
  logic [IW-1:0] IF_ID_INSTR;
  logic          IF_ID_VALID;
  logic [AW-1:0] target = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  int lat_max  = 0;

  item_t exp_q[$];

  always #5 CLK = ~CLK;

  fetch_unit_if imem();

  fetch_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .STALL       (STALL),
    .BRANCH_FLUSH(BRANCH_FLUSH),
    .busyWait    (busyWait),
    .imem        (imem),
    .IF_ID_PC    (IF_ID_PC),
    .IF_ID_INSTR (IF_ID_INSTR),
    .IF_ID_VALID (IF_ID_VALID)
  );

  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // PC stage: advance once per delivered instruction, or jump on flush
  logic rst_at_edge = 1'b1;
  logic flush_at_edge = 1'b0;
  always @(posedge CLK) begin
    rst_at_edge   <= RESET;
    flush_at_edge <= BRANCH_FLUSH && !RESET;
    if (RESET) begin
      PC <= '0;
      exp_q.delete();
    end else if (!busyWait) begin
      if (BRANCH_FLUSH) PC <= target;
      else begin
        exp_q.push_back('{pc: PC, instr: instr_of(PC)});
        PC <= PC + 4;
      end
    end
  end

  // instruction memory with random per-request latency
  logic          mem_active = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  int            mem_wait = 0;
  int            next_lat = 0;
  always @(negedge CLK) begin
    next_lat <= $urandom_range(0, lat_max);
    if (!imem.imem_read) begin
      mem_active         <= 1'b0;
      imem.imem_busywait <= 1'b1;
    end else begin
      if (!mem_active) begin
        check("launch_addr", imem.imem_address, PC);
        mem_active         <= 1'b1;
        mem_addr           <= imem.imem_address;
        mem_wait           <= (next_lat == 0) ? 0 : next_lat - 1;
        imem.imem_busywait <= (next_lat != 0);
      end else begin
        check("addr_stable", imem.imem_address, mem_addr);
        if (mem_wait > 0) mem_wait <= mem_wait - 1;
        imem.imem_busywait <= (mem_wait > 0);
      end
      imem.imem_readdata <= instr_of(imem.imem_address);
    end
  end

  // monitor: a new IF/ID content is a delivery and must match the scoreboard head
  logic          prev_valid = 1'b0;
  logic [AW-1:0] prev_pc = '0;
  always @(negedge CLK) begin
    if (!rst_at_edge) begin
      if (IF_ID_VALID && (!prev_valid || IF_ID_PC != prev_pc)) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_delivery: got pc %h, expected no delivery", IF_ID_PC);
        end else begin
          check("deliv_pc", IF_ID_PC, exp_q[0].pc);
          check("deliv_instr", IF_ID_INSTR, exp_q[0].instr);
          void'(exp_q.pop_front());
        end
      end
      if (flush_at_edge) begin
        check("flush_valid", IF_ID_VALID, 1'b0);
        check("flush_instr", IF_ID_INSTR, NOP);
      end
      check("pending_empty", exp_q.size(), 0);
    end
    prev_valid <= rst_at_edge ? 1'b0 : IF_ID_VALID;
    prev_pc    <= IF_ID_PC;
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    bit found;
    repeat (3) step();
    check("rst_read", imem.imem_read, 1'b0);
    check("rst_addr", imem.imem_address, 0);
    check("rst_if_pc", IF_ID_PC, 0);
    check("rst_if_instr", IF_ID_INSTR, NOP);
    check("rst_if_valid", IF_ID_VALID, 1'b0);
    check("rst_busywait", busyWait, 1'b1);
    RESET = 1'b0;

    // single-cycle memory: PC 0 is requested on edge 1 and lands in IF/ID on edge 2
    step();
    check("lat_read", imem.imem_read, 1'b1);
    check("lat_addr", imem.imem_address, 0);
    check("lat_valid_early", IF_ID_VALID, 1'b0);
    check("lat_busywait_done", busyWait, 1'b0);
    step();
    check("lat_valid", IF_ID_VALID, 1'b1);
    check("lat_pc", IF_ID_PC, 0);
    check("lat_instr", IF_ID_INSTR, instr_of(0));
    check("lat_read_drop", imem.imem_read, 1'b0);
    check("lat_busywait_idle", busyWait, 1'b1);
    repeat (6) step();

    lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      step();
      STALL        = ($urandom_range(0, 3) == 0);
      BRANCH_FLUSH = ($urandom_range(0, 9) == 0);
      target       = AW'($urandom_range(0, 63) * 4);
      #1;
      if (BRANCH_FLUSH) check("flush_busywait", busyWait, 1'b0);
    end

    // reset while a read is outstanding
    STALL = 1'b0;
    BRANCH_FLUSH = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = imem.imem_read && imem.imem_busywait;
    end
    check("midrst_found_busy_req", found, 1'b1);
    RESET = 1'b1;
    #1;
    check("midrst_busywait", busyWait, 1'b1);
    step();
    check("midrst_read", imem.imem_read, 1'b0);
    check("midrst_valid", IF_ID_VALID, 1'b0);
    check("midrst_if_pc", IF_ID_PC, 0);
    RESET = 1'b0;

    for (int i = 0; i < 40; i++) step();
    check("final_pending_empty", exp_q.size(), 0);
    check("deliveries_seen", (n_deliv > 100), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
